// File: rtl/dir_pkg.sv
// Shared types for the direction/speed command scheduler:
// speed levels, direction, FSM states, request sources, command bundle.
package dir_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        SLOW   = 2'd1,
        MEDIUM = 2'd2,
        FAST   = 2'd3
    } spd_e;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_BRAKE = 3'd2,
        S_DWELL = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_MAN  = 2'b01,
        SRC_AUTO = 2'b10
    } src_e;

    typedef struct packed {
        dir_e dir;
        spd_e spd;
    } cmd_t;

    // One level toward tgt, saturating at STOP and FAST.
    function automatic spd_e step_toward(spd_e cur, spd_e tgt);
        logic [1:0] c;
        c = cur;
        if (tgt > cur && c != 2'd3)
            c = c + 2'd1;
        else if (tgt < cur && c != 2'd0)
            c = c - 2'd1;
        return spd_e'(c);
    endfunction

endpackage

// File: rtl/dir_cmd_sched_cyc_timer.sv
// Loadable down-counter; o_zero flags terminal count.
// Ports: clk, resetn, i_load/i_val (load wins), i_en (decrement), o_zero.
module cyc_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dir_cmd_sched.sv
// Arbitrates manual/auto speed requests, ramps one level per step,
// brakes and dwells before reversals, with watchdog and emergency stop.
// Ports: clk, resetn, estop; man_/auto_ valid, cmd, hold, ready;
// cmds {dir,spd}, active_src (01 man, 10 auto), wdog_trip (sticky).
module dir_cmd_sched
    import dir_pkg::*;
#(
    parameter int RAMP_CYC  = 1000,
    parameter int DWELL_CYC = 5000,
    parameter int WDOG_CYC  = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        estop,
    input  logic        man_valid,
    input  logic [2:0]  man_cmd,
    input  logic [15:0] man_hold,
    output logic        man_ready,
    input  logic        auto_valid,
    input  logic [2:0]  auto_cmd,
    input  logic [15:0] auto_hold,
    output logic        auto_ready,
    output logic [2:0]  cmds,
    output logic [1:0]  active_src,
    output logic        wdog_trip
);

    localparam logic [CNT_W-1:0] L_RAMP  = CNT_W'(RAMP_CYC - 1);
    localparam logic [CNT_W-1:0] L_DWELL = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] L_WDOG  = CNT_W'(WDOG_CYC - 1);

    state_e      r_state, w_state_n;
    cmd_t        r_cur, w_cur_n;
    cmd_t        r_tgt, w_tgt_n;
    logic [15:0] r_hold, w_hold_n;
    src_e        r_src, w_src_n;
    logic        r_trip, w_trip_n;

    logic             w_stp_ld, w_stp_en, w_stp_zero, w_stp_tc;
    logic [CNT_W-1:0] w_stp_val;
    logic             w_wd_ld, w_wd_en, w_wd_zero, w_wd_tc;
    logic [CNT_W-1:0] w_wd_val;
    logic             w_hd_ld, w_hd_en, w_hd_zero, w_hd_tc;
    logic [15:0]      w_hd_val;

    logic        w_idle_hold;
    logic        w_man_acc, w_auto_acc, w_acc;
    cmd_t        w_req;
    logic [15:0] w_req_hold;

    assign w_idle_hold = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign man_ready   = !estop && (w_idle_hold || r_src == SRC_AUTO);
    assign auto_ready  = !estop && !man_valid && w_idle_hold
                         && r_src != SRC_MAN;

    assign w_man_acc  = man_valid && man_ready;
    assign w_auto_acc = auto_valid && auto_ready;
    assign w_acc      = w_man_acc || w_auto_acc;
    assign w_req      = w_man_acc ? cmd_t'(man_cmd) : cmd_t'(auto_cmd);
    assign w_req_hold = w_man_acc ? man_hold : auto_hold;

    assign w_stp_en = r_state inside {S_RAMP, S_BRAKE, S_DWELL};
    assign w_wd_en  = (r_state != S_IDLE);
    assign w_hd_en  = (r_state == S_HOLD);
    assign w_stp_tc = w_stp_en && w_stp_zero;
    assign w_wd_tc  = w_wd_en && w_wd_zero;
    // A zero hold value means hold indefinitely.
    assign w_hd_tc  = w_hd_en && w_hd_zero && (r_hold != 16'd0);

    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cur;
        w_tgt_n   = r_tgt;
        w_hold_n  = r_hold;
        w_src_n   = r_src;
        w_trip_n  = r_trip;
        w_stp_ld  = 1'b0;
        w_stp_val = L_RAMP;
        w_wd_ld   = 1'b0;
        w_wd_val  = L_WDOG;
        w_hd_ld   = 1'b0;
        w_hd_val  = r_hold - 16'd1;
        if (estop) begin
            w_state_n   = S_IDLE;
            w_cur_n.spd = STOP;
            w_tgt_n.spd = STOP;
            w_src_n     = SRC_NONE;
            w_stp_ld    = 1'b1;
            w_stp_val   = '0;
            w_wd_ld     = 1'b1;
            w_wd_val    = '0;
            w_hd_ld     = 1'b1;
            w_hd_val    = '0;
        end else if (w_acc) begin
            w_tgt_n  = w_req;
            w_hold_n = w_req_hold;
            w_src_n  = w_man_acc ? SRC_MAN : SRC_AUTO;
            w_trip_n = 1'b0;
            w_wd_ld  = 1'b1;
            w_stp_ld = 1'b1;
            if (w_req == r_cur) begin
                w_state_n = S_HOLD;
                w_hd_ld   = 1'b1;
                w_hd_val  = w_req_hold - 16'd1;
            end else if (w_req.dir != r_cur.dir) begin
                // A reversal already under way keeps its own timing.
                if (r_state == S_BRAKE || r_state == S_DWELL) begin
                    w_stp_ld = 1'b0;
                end else if (r_cur.spd != STOP) begin
                    w_state_n = S_BRAKE;
                end else begin
                    w_cur_n.dir = w_req.dir;
                    w_state_n   = S_RAMP;
                end
            end else begin
                w_state_n = S_RAMP;
            end
        end else if (w_wd_tc) begin
            w_trip_n    = 1'b1;
            w_tgt_n.spd = STOP;
            w_state_n   = S_RAMP;
            w_stp_ld    = 1'b1;
            w_wd_ld     = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_RAMP: begin
                    if (r_cur.spd == r_tgt.spd || w_stp_tc) begin
                        if (r_cur.spd != r_tgt.spd) begin
                            w_cur_n.spd = step_toward(r_cur.spd, r_tgt.spd);
                            w_stp_ld    = 1'b1;
                        end
                        if (w_cur_n.spd == r_tgt.spd) begin
                            if (r_tgt.spd == STOP) begin
                                w_state_n = S_IDLE;
                                w_src_n   = SRC_NONE;
                            end else begin
                                w_state_n = S_HOLD;
                                w_hd_ld   = 1'b1;
                            end
                        end
                    end
                end
                S_BRAKE: begin
                    if (w_stp_tc || r_cur.spd == STOP) begin
                        w_cur_n.spd = step_toward(r_cur.spd, STOP);
                        w_stp_ld    = 1'b1;
                        if (w_cur_n.spd == STOP) begin
                            w_state_n = S_DWELL;
                            w_stp_val = L_DWELL;
                        end
                    end
                end
                S_DWELL: begin
                    if (w_stp_tc) begin
                        w_cur_n.dir = r_tgt.dir;
                        w_state_n   = S_RAMP;
                        w_stp_ld    = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_hd_tc) begin
                        w_tgt_n.spd = STOP;
                        w_state_n   = S_RAMP;
                        w_stp_ld    = 1'b1;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_tgt   <= '0;
            r_hold  <= '0;
            r_src   <= SRC_NONE;
            r_trip  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cur   <= w_cur_n;
            r_tgt   <= w_tgt_n;
            r_hold  <= w_hold_n;
            r_src   <= w_src_n;
            r_trip  <= w_trip_n;
        end
    end

    cyc_timer #(.W(CNT_W)) u_step (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_stp_ld),
        .i_val  (w_stp_val),
        .i_en   (w_stp_en),
        .o_zero (w_stp_zero)
    );

    cyc_timer #(.W(CNT_W)) u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_wd_ld),
        .i_val  (w_wd_val),
        .i_en   (w_wd_en),
        .o_zero (w_wd_zero)
    );

    cyc_timer #(.W(16)) u_hold (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_hd_ld),
        .i_val  (w_hd_val),
        .i_en   (w_hd_en),
        .o_zero (w_hd_zero)
    );

    assign cmds       = r_cur;
    assign active_src = r_src;
    assign wdog_trip  = r_trip;

endmodule

// File: tb/tb_dir_cmd_sched.sv
// Bench for dir_cmd_sched: expected cmds trajectories are queued as
// (cycle, value) events; a monitor pops one on every cmds change.
module tb_dir_cmd_sched;

    localparam int RC = 4;
    localparam int DC = 8;
    localparam int WC = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        estop = 1'b0;
    logic        man_valid = 1'b0;
    logic [2:0]  man_cmd = 3'd0;
    logic [15:0] man_hold = 16'd0;
    logic        man_ready;
    logic        auto_valid = 1'b0;
    logic [2:0]  auto_cmd = 3'd0;
    logic [15:0] auto_hold = 16'd0;
    logic        auto_ready;
    logic [2:0]  cmds;
    logic [1:0]  active_src;
    logic        wdog_trip;

    dir_cmd_sched #(
        .RAMP_CYC (RC),
        .DWELL_CYC(DC),
        .WDOG_CYC (WC),
        .CNT_W    (20)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .estop      (estop),
        .man_valid  (man_valid),
        .man_cmd    (man_cmd),
        .man_hold   (man_hold),
        .man_ready  (man_ready),
        .auto_valid (auto_valid),
        .auto_cmd   (auto_cmd),
        .auto_hold  (auto_hold),
        .auto_ready (auto_ready),
        .cmds       (cmds),
        .active_src (active_src),
        .wdog_trip  (wdog_trip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [2:0] v;
    } ev_t;

    ev_t        q[$];
    int         n_pass = 0;
    int         n_tot = 0;
    logic [2:0] last = 3'd0;
    bit         m_dir = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     nm, act, exp, cyc);
    endtask

    // Monitor: every change of cmds must match the next queued event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (cmds !== last) begin
                if (q.size() == 0) begin
                    n_tot++;
                    $display("FAIL cmds_unexpected: got %b from %b (cycle %0d)",
                             cmds, last, cyc);
                end else begin
                    e = q.pop_front();
                    chk("cmds_val", int'(cmds), int'(e.v));
                    chk("cmds_cyc", cyc, e.t);
                end
                last = cmds;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_ev(input int t, input logic [2:0] v);
        ev_t e;
        e.t = t;
        e.v = v;
        q.push_back(e);
    endtask

    // Speed walks one level per RC cycles from 'from' to 'to'.
    task automatic push_steps(input bit d, input int from, input int to,
                              input int t0, output int tend);
        int sp;
        int t;
        sp = from;
        t  = t0;
        while (sp != to) begin
            sp += (to > sp) ? 1 : -1;
            t  += RC;
            push_ev(t, {d, 2'(sp)});
        end
        tend = t;
    endtask

    // Direction change from standstill shows up at the accept edge.
    task automatic dir_ev(input bit d, input int n);
        if (d != m_dir) push_ev(n, {d, 2'b00});
        m_dir = d;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", q.size(), 0);
        q.delete();
    endtask

    task automatic issue(input bit man, input logic [2:0] c,
                         input logic [15:0] h, output int n);
        @(negedge clk);
        if (man) begin
            man_valid = 1'b1;
            man_cmd   = c;
            man_hold  = h;
        end else begin
            auto_valid = 1'b1;
            auto_cmd   = c;
            auto_hold  = h;
        end
        #1;
        if (man) chk("man_ready", int'(man_ready), 1);
        else     chk("auto_ready", int'(auto_ready), 1);
        @(posedge clk);
        #1;
        n = cyc;
        man_valid  = 1'b0;
        auto_valid = 1'b0;
        chk("accept_src", int'(active_src), man ? 1 : 2);
    endtask

    task automatic idle_checks();
        @(negedge clk);
        chk("idle_auto_ready", int'(auto_ready), 1);
        chk("idle_src", int'(active_src), 0);
    endtask

    task automatic run_simple(input bit man, input bit d,
                              input int s, input int h);
        int n, t, t2;
        issue(man, {d, 2'(s)}, 16'(h), n);
        chk("wdog_clr", int'(wdog_trip), 0);
        dir_ev(d, n);
        push_steps(d, 0, s, n, t);
        push_steps(d, s, 0, t + h, t2);
        drain(t2 - cyc + 10);
        idle_checks();
    endtask

    task automatic reversal(input bit src1, input bit d, input int s1,
                            input int s2, input int h2);
        int n, t, m, b, e, x;
        issue(src1, {d, 2'(s1)}, 16'd0, n);
        dir_ev(d, n);
        push_steps(d, 0, s1, n, t);
        drain(t - cyc + 10);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        issue(1'b1, {~d, 2'(s2)}, 16'(h2), m);
        push_steps(d, s1, 0, m, b);
        push_ev(b + DC, {~d, 2'b00});
        m_dir = ~d;
        push_steps(~d, 0, s2, b + DC, e);
        wait_cyc(e);
        chk("rev_hold_src", int'(active_src), 1);
        push_steps(~d, s2, 0, e + h2, x);
        drain(x - cyc + 10);
        idle_checks();
    endtask

    initial begin
        int n, t, x;
        repeat (2) @(negedge clk);
        chk("rst_cmds", int'(cmds), 0);
        chk("rst_src", int'(active_src), 0);
        chk("rst_wdog", int'(wdog_trip), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_man_ready", int'(man_ready), 1);
        chk("rst_auto_ready", int'(auto_ready), 1);

        // Ramp up, hold 10, ramp down.
        run_simple(1'b0, 1'b0, 3, 10);

        // Reversal 010 -> 110, then randomized reversals.
        reversal(1'b0, 1'b0, 2, 2, 6);
        repeat (4)
            reversal(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(1, 15));

        // Arbitration: both valid in IDLE, manual wins.
        @(negedge clk);
        man_valid  = 1'b1;
        man_cmd    = 3'b001;
        man_hold   = 16'd20;
        auto_valid = 1'b1;
        auto_cmd   = 3'b111;
        auto_hold  = 16'd5;
        #1;
        chk("arb_man_ready", int'(man_ready), 1);
        chk("arb_auto_ready", int'(auto_ready), 0);
        @(posedge clk);
        #1;
        n = cyc;
        man_valid  = 1'b0;
        auto_valid = 1'b0;
        chk("arb_src", int'(active_src), 1);
        dir_ev(1'b0, n);
        push_steps(1'b0, 0, 1, n, t);
        push_steps(1'b0, 1, 0, t + 20, x);
        wait_cyc(t + 2);
        auto_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("arb_hold_auto_ready", int'(auto_ready), 0);
            chk("arb_hold_src", int'(active_src), 1);
            @(negedge clk);
        end
        auto_valid = 1'b0;
        drain(x - cyc + 10);
        idle_checks();

        // Watchdog: indefinite hold with no further requests.
        issue(1'b1, 3'b011, 16'd0, n);
        dir_ev(1'b0, n);
        push_steps(1'b0, 0, 3, n, t);
        push_steps(1'b0, 3, 0, n + WC, x);
        wait_cyc(n + WC - 1);
        chk("wdog_early", int'(wdog_trip), 0);
        wait_cyc(n + WC);
        chk("wdog_fire", int'(wdog_trip), 1);
        drain(x - cyc + 10);
        idle_checks();
        chk("wdog_sticky", int'(wdog_trip), 1);
        run_simple(1'b0, 1'b0, 1, 2);

        // Emergency stop mid-ramp at 010.
        issue(1'b0, 3'b011, 16'd0, n);
        dir_ev(1'b0, n);
        push_steps(1'b0, 0, 2, n, t);
        wait_cyc(n + 2 * RC);
        estop     = 1'b1;
        man_valid = 1'b1;
        man_cmd   = 3'b010;
        man_hold  = 16'd3;
        push_ev(n + 2 * RC + 1, 3'b000);
        repeat (3) begin
            #1;
            chk("estop_man_ready", int'(man_ready), 0);
            chk("estop_auto_ready", int'(auto_ready), 0);
            @(negedge clk);
        end
        chk("estop_src", int'(active_src), 0);
        man_valid = 1'b0;
        estop     = 1'b0;
        #1;
        chk("estop_rel_ready", int'(auto_ready), 1);
        drain(4);
        run_simple(1'b1, 1'b0, 2, 3);

        // Randomized single requests from IDLE.
        repeat (5)
            run_simple(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(1, 3), $urandom_range(1, 30));

        // Asynchronous reset while holding 111.
        issue(1'b1, 3'b111, 16'd0, n);
        dir_ev(1'b1, n);
        push_steps(1'b1, 0, 3, n, t);
        wait_cyc(t + 2);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        push_ev(cyc, 3'b000);
        #1;
        chk("arst_cmds", int'(cmds), 0);
        chk("arst_src", int'(active_src), 0);
        m_dir = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        drain(4);
        run_simple(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 3), $urandom_range(1, 20));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
